score_sum_readout: RTL and testbench
====================================

// Module: score_sum_readout
// PURPOSE
//  Drains the accumulated score-sum table after all diffusion add-up passes finish.
//  Scans addresses 0..mem_size-1 and streams (node, score) pairs whose sum >= threshold
//  over a valid/ready port to the PS-side collector. Optionally zeroes each entry after
//  reading so the table is clean for the next query. It is the reader end of the
//  score-sum memory port that add-up writes.
// PARAMETERS
//  DATA_WIDTH   32    score word width
//  ADDR_WIDTH   13    score-sum table address width
//  mem_size     8192  number of table entries scanned (<= 2**ADDR_WIDTH)
//  RD_LATENCY   1     cycles from address presented to data_in_score_sum valid (>=1)
// PORTS
//  clk                 in   1             clock, rising edge
//  rst                 in   1             synchronous active-high reset
//  start               in   1             begin scan (ignored unless IDLE or DONE)
//  threshold           in   DATA_WIDTH    unsigned emit threshold, sampled at start
//  clear_en            in   1             zero entries after read, sampled at start
//  addr_score_sum      out  ADDR_WIDTH    score-sum table address
//  score_write_sum_en  out  1             table write enable (clear writes only)
//  data_out_score_sum  out  DATA_WIDTH    table write data, constant 0
//  data_in_score_sum   in   DATA_WIDTH    table read data
//  out_valid           out  1             stream word valid
//  out_ready           in   1             downstream accepts word
//  out_node            out  ADDR_WIDTH    node index (table address) of word
//  out_score           out  DATA_WIDTH    score sum of word
//  busy                out  1             scan in progress
//  done                out  1             scan complete, held until start or rst
//  count_out           out  ADDR_WIDTH+1  number of words emitted this scan
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; addr counter 0; latched threshold/clear_en 0.
//  States: IDLE, ISSUE, WAIT, EVAL, EMIT, CLEAR, DONE. busy=1 in every state but IDLE/DONE.
//  IDLE/DONE + start: latch threshold, clear_en; addr=0; count_out=0; done=0; -> ISSUE.
//  ISSUE: drive addr_score_sum=addr; 1 cycle -> WAIT.
//  WAIT: hold addr for RD_LATENCY cycles (down-counter); then -> EVAL.
//  EVAL: capture data_in_score_sum into score_reg. If score_reg >= threshold (unsigned),
//   -> EMIT; else -> CLEAR. threshold=0 emits every entry, including zero entries.
//  EMIT: out_valid=1; out_node=addr; out_score=score_reg, stable while valid && !ready.
//   On out_valid && out_ready: count_out+1; out_valid drops next cycle; -> CLEAR.
//  CLEAR: exactly 1 cycle always (fixed timing). If latched clear_en, score_write_sum_en=1
//   with addr_score_sum=addr and data 0; else write_en stays 0. Then if addr==mem_size-1
//   -> DONE, else addr+1 -> ISSUE. addr never wraps past mem_size-1.
//  DONE: done=1; busy=0; count_out holds final value; start restarts the scan.
//  Per-entry cost without stall: 3+RD_LATENCY cycles; EMIT adds >=1 cycle.
//  score_write_sum_en is high only in CLEAR. There is never a read and a write in the same cycle.
//  start while busy: ignored. threshold/clear_en changes mid-scan: no effect.
//  rst mid-scan (including mid-EMIT or mid-CLEAR): next edge -> IDLE with all outputs 0.
//   The current word is dropped and no write is issued.
//  out_ready high while out_valid=0: no effect.
// TESTING
//  T1 mem_size=8, table={0,5,0,9,1,0,7,2}, threshold=3, ready=1, clear_en=0 ->
//     stream (1,5),(3,9),(6,7); count_out=3; done=1; table unchanged.
//  T2 same table, threshold=0, clear_en=1 -> 8 words emitted in address order;
//     afterwards all 8 entries read 0; 8 write pulses, each 1 cycle, data 0.
//  T3 T1 with out_ready held 0 for 5 cycles on each valid -> out_node/out_score stable
//     while stalled; same 3 words, no duplicates, count_out=3.
//  T4 RD_LATENCY=3 with a memory model of matching latency -> correct values;
//     no-emit scan of 8 entries finishes in 8*(3+3) cycles +/-1.
//  T5 rst asserted during EMIT of node 3 (T1 setup) -> next cycle out_valid=0, busy=0,
//     write_en=0; restart -> full T1 stream reproduced.
//  T6 start pulsed while busy and threshold changed mid-scan -> scan unaffected; a second
//     start in DONE clears done/count_out and rescans with the new threshold.

Source files
------------

// File: rtl/score_sum_readout.sv
// Score-sum table readout: scans every entry, streams (node, score) pairs at or above
// a threshold over valid/ready, and optionally zeroes each entry once it has been read.
module score_sum_readout #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int mem_size   = 8192,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic                  clear_en,
  output logic [ADDR_WIDTH-1:0] addr_score_sum,
  output logic                  score_write_sum_en,
  output logic [DATA_WIDTH-1:0] data_out_score_sum,
  input  logic [DATA_WIDTH-1:0] data_in_score_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_node,
  output logic [DATA_WIDTH-1:0] out_score,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_EMIT  = 3'd4,
    S_CLEAR = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(mem_size - 1);
  localparam logic [LW-1:0]         WAIT_LOAD = LW'(RD_LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] score_reg;
  logic [DATA_WIDTH-1:0] thr_latched;
  logic                  clr_latched;
  logic                  start_ok;
  logic                  handshake;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign handshake = out_valid && out_ready;

  // The address stays on the port from ISSUE through CLEAR, so the read and the
  // optional clear write share it and never overlap in time.
  assign addr_score_sum     = addr;
  assign out_node           = addr;
  assign out_score          = score_reg;
  assign data_out_score_sum = {DATA_WIDTH{1'b0}};

  // Next-state decode for the scan sequencer.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_ISSUE;
        else       state_next = state;
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == {LW{1'b0}}) state_next = S_EVAL;
        else                        state_next = S_WAIT;
      end
      S_EVAL: begin
        if (data_in_score_sum >= thr_latched) state_next = S_EMIT;
        else                                  state_next = S_CLEAR;
      end
      S_EMIT: begin
        if (handshake) state_next = S_CLEAR;
        else           state_next = S_EMIT;
      end
      S_CLEAR: begin
        if (addr == LAST_ADDR) state_next = S_DONE;
        else                   state_next = S_ISSUE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus status/handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      out_valid          <= 1'b0;
      score_write_sum_en <= 1'b0;
    end else begin
      state              <= state_next;
      busy               <= !((state_next == S_IDLE) || (state_next == S_DONE));
      done               <= (state_next == S_DONE);
      out_valid          <= (state_next == S_EMIT);
      score_write_sum_en <= (state_next == S_CLEAR) && clr_latched;
    end
  end

  // Scan configuration, address walk and emitted-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_latched <= {DATA_WIDTH{1'b0}};
      clr_latched <= 1'b0;
      addr        <= {ADDR_WIDTH{1'b0}};
      count_out   <= {(ADDR_WIDTH+1){1'b0}};
    end else if (start_ok) begin
      thr_latched <= threshold;
      clr_latched <= clear_en;
      addr        <= {ADDR_WIDTH{1'b0}};
      count_out   <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if ((state == S_CLEAR) && (state_next == S_ISSUE)) begin
        addr <= addr + ADDR_WIDTH'(1);
      end
      if (handshake) begin
        count_out <= count_out + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Read-latency down-counter and captured score word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= {LW{1'b0}};
      score_reg <= {DATA_WIDTH{1'b0}};
    end else begin
      if (state == S_ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == S_WAIT) && (wait_cnt != {LW{1'b0}})) begin
        wait_cnt <= wait_cnt - LW'(1);
      end
      if (state == S_EVAL) begin
        score_reg <= data_in_score_sum;
      end
    end
  end

endmodule

// File: tb/tb_score_sum_readout.sv
// Scoreboard bench for score_sum_readout: a behavioural table model predicts the emitted
// stream, which a separate monitor checks word by word along with stall and write rules.
module tb_score_sum_readout;

  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int MS  = 8;
  localparam int RDL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] threshold;
  logic          clear_en;
  logic [AW-1:0] addr_score_sum;
  logic          we;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_node;
  logic [DW-1:0] out_score;
  logic          busy;
  logic          done;
  logic [AW:0]   count_out;

  always #5 clk = ~clk;

  score_sum_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .mem_size(MS), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold), .clear_en(clear_en),
    .addr_score_sum(addr_score_sum), .score_write_sum_en(we), .data_out_score_sum(data_out),
    .data_in_score_sum(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_node(out_node), .out_score(out_score), .busy(busy), .done(done), .count_out(count_out)
  );

  logic [DW-1:0] mem     [MS];
  logic [DW-1:0] rd_pipe [RDL];
  assign data_in = rd_pipe[RDL-1];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            wr_total = 0;
  int            rdy_mode = 0;
  int            exp_node_q[$];
  logic [DW-1:0] exp_score_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Table memory with a RDL-cycle read pipeline and a clearing write port.
  initial forever begin
    @(posedge clk);
    if (we) mem[addr_score_sum] <= '0;
    rd_pipe[0] <= mem[addr_score_sum];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Downstream ready: 0 always ready, 1 stall 5 cycles per word, 2 random, 3 block node 3.
  initial begin
    int sc;
    sc = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          if (!out_valid) begin sc = 0; out_ready = 1'b0; end
          else if (sc < 5) begin sc++; out_ready = 1'b0; end
          else out_ready = 1'b1;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(out_valid && (out_node == 3'd3));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall/write behaviour.
  initial begin
    logic          pv, pr, pw;
    logic [AW-1:0] pn;
    logic [DW-1:0] ps;
    int            en;
    logic [DW-1:0] es;
    pv = 1'b0; pr = 1'b0; pw = 1'b0; pn = '0; ps = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; pw = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("stall_valid", out_valid, 1);
          check("stall_node", out_node, pn);
          check("stall_score", out_score, ps);
        end
        if (we) begin
          wr_total++;
          check("wr_data", data_out, 0);
          check("wr_pulse_1cyc", pw, 0);
          check("wr_no_emit", out_valid, 0);
        end
        if (out_valid && out_ready) begin
          if (exp_node_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_word: got node %0d score %0d, expected no word", out_node, out_score);
          end else begin
            en = exp_node_q.pop_front();
            es = exp_score_q.pop_front();
            check("word_node", out_node, en);
            check("word_score", out_score, es);
          end
        end
        pv = out_valid; pr = out_ready; pw = we; pn = out_node; ps = out_score;
      end
    end
  end

  // Reference: every entry in address order whose value is >= thr, unsigned.
  function automatic int model(input logic [DW-1:0] thr);
    int n;
    n = 0;
    for (int a = 0; a < MS; a++) begin
      if (mem[a] >= thr) begin
        exp_node_q.push_back(a);
        exp_score_q.push_back(mem[a]);
        n++;
      end
    end
    return n;
  endfunction

  task automatic load_t1();
    logic [DW-1:0] t1 [MS];
    t1 = '{32'd0, 32'd5, 32'd0, 32'd9, 32'd1, 32'd0, 32'd7, 32'd2};
    for (int a = 0; a < MS; a++) mem[a] = t1[a];
  endtask

  task automatic do_scan(input string tag, input logic [DW-1:0] thr, input logic clr, input int mode);
    int            n_exp, cyc, wr0, base;
    logic [DW-1:0] ref_tab [MS];
    rdy_mode = mode;
    for (int a = 0; a < MS; a++) ref_tab[a] = mem[a];
    exp_node_q.delete();
    exp_score_q.delete();
    n_exp = model(thr);
    wr0   = wr_total;
    @(posedge clk); #1;
    threshold = thr; clear_en = clr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; threshold = ~thr; clear_en = ~clr;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_done_cleared"}, done, 0);
    check({tag, "_count_cleared"}, count_out, 0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 7);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_count"}, count_out, n_exp);
    check({tag, "_queue_left"}, exp_node_q.size(), 0);
    check({tag, "_writes"}, wr_total - wr0, clr ? MS : 0);
    if (mode == 0) begin
      base = MS * (3 + RDL) + n_exp;
      n_checks++;
      if (cyc < base - 1 || cyc > base + 1) begin
        n_fail++;
        $display("FAIL %s_cycles: got %0d, expected %0d +/-1", tag, cyc, base);
      end
    end
    for (int a = 0; a < MS; a++) check({tag, "_table"}, mem[a], clr ? 0 : ref_tab[a]);
    exp_node_q.delete();
    exp_score_q.delete();
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; threshold = '0; clear_en = 1'b0;
    load_t1();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count_out, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr_score_sum, 0);
    check("rst_score", out_score, 0);
    rst = 1'b0;

    do_scan("t1", 32'd3, 1'b0, 0);
    do_scan("t3", 32'd3, 1'b0, 1);
    do_scan("t6", 32'd9, 1'b0, 0);
    do_scan("t2", 32'd0, 1'b1, 0);
    load_t1();
    do_scan("t4", 32'hFFFF_FFFF, 1'b0, 0);

    // Reset while node 3 is held in EMIT, then a clean rescan.
    load_t1();
    rdy_mode = 3;
    exp_node_q.delete();
    exp_score_q.delete();
    void'(model(32'd3));
    @(posedge clk); #1;
    threshold = 32'd3; clear_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(out_valid && out_node == 3'd3) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t5_reach_node3", out_valid && (out_node == 3'd3), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_we", we, 0);
    check("t5_count", count_out, 0);
    rst = 1'b0;
    do_scan("t5", 32'd3, 1'b0, 0);

    for (int k = 0; k < 6; k++) begin
      for (int a = 0; a < MS; a++) mem[a] = ($urandom_range(0, 3) == 0) ? 32'd0 : DW'($urandom_range(0, 20));
      do_scan("rnd", DW'($urandom_range(0, 21)), 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0) ? 0 : 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
